// File: rtl/edge_capture_monitor_if.sv
// Host read port of edge_capture_monitor.
//   rd_en    : host pops the head entry (ignored while rd_valid=0)
//   rd_valid : FIFO holds at least one entry
//   rd_data  : value of the head entry (show-ahead)
//   rd_ts    : timestamp of the head entry (show-ahead)
interface edge_capture_monitor_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned TS_W   = 12
);
    logic              rd_en;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   rd_ts;

    modport master (output rd_en, input rd_valid, rd_data, rd_ts);
    modport slave  (input rd_en, output rd_valid, rd_data, rd_ts);
endinterface

// File: rtl/edge_capture_monitor.sv
// Samples a bus every sysclk while enabled, timestamps each value change and
// queues {timestamp, value} in a show-ahead FIFO drained by a host.
//   sysclk, sysrst_n : clock, asynchronous active-low reset
//   en               : capture enable (level)
//   clr              : synchronous flush of FIFO, overflow and ts_wrap
//   in_data          : monitored bus
//   rd               : host read port (rd_en / rd_valid / rd_data / rd_ts)
//   count            : entries currently held
//   overflow         : sticky, a change was dropped on a full FIFO
//   ts_wrap          : sticky, the timestamp counter wrapped while running
module edge_capture_monitor #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned TS_W   = 12,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     sysclk,
    input  logic                     sysrst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        in_data,
    edge_capture_monitor_if.slave    rd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     ts_wrap
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = TS_W + DATA_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [TS_W-1:0]    ts_cnt;
    logic [TS_W-1:0]    s_ts;
    logic [DATA_W-1:0]  s_val;
    logic               push_pend;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               rd_valid_q;

    logic               first_c, push_req_c, pop_c, full_c, wr_ok_c, drop_c;
    logic [TS_W-1:0]    ts_inc_c;
    logic [CNT_W-1:0]   cnt_d;

    // State register
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state plus capture/FIFO control decisions
    always_comb begin
        state_d    = state_q;
        first_c    = 1'b0;
        push_req_c = 1'b0;
        pop_c      = rd.rd_en && rd_valid_q;
        full_c     = (count == CNT_W'(DEPTH));
        ts_inc_c   = ts_cnt + TS_W'(1);
        cnt_d      = count;
        case (state_q)
            IDLE: if (en) begin
                state_d    = RUN;
                first_c    = 1'b1;
                push_req_c = 1'b1;            // baseline sample always queued
            end
            RUN: begin
                if (!en) state_d = IDLE;
                else     push_req_c = (in_data != s_val);
            end
            default: state_d = IDLE;
        endcase
        // A full FIFO still takes a push when the head leaves on the same edge
        wr_ok_c = push_pend && (!full_c || pop_c);
        drop_c  = push_pend && full_c && !pop_c;
        case ({wr_ok_c, pop_c})
            2'b10:   cnt_d = count + CNT_W'(1);
            2'b01:   cnt_d = count - CNT_W'(1);
            default: cnt_d = count;
        endcase
    end

    // Sampler, timestamp counter and FIFO storage
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            ts_cnt     <= '0;
            s_ts       <= '0;
            s_val      <= '0;
            push_pend  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid_q <= 1'b0;
            overflow   <= 1'b0;
            ts_wrap    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (en) begin
                s_val <= in_data;
                if (first_c) begin
                    s_ts   <= '0;
                    ts_cnt <= '0;
                end else begin
                    s_ts   <= ts_inc_c;
                    ts_cnt <= ts_inc_c;
                end
            end
            push_pend <= push_req_c && !clr;

            if (clr) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                rd_valid_q <= 1'b0;
                overflow   <= 1'b0;
                ts_wrap    <= 1'b0;
            end else begin
                if (wr_ok_c) begin
                    mem[wr_ptr] <= {s_ts, s_val};
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
                count      <= cnt_d;
                rd_valid_q <= (cnt_d != '0);
                if (drop_c) overflow <= 1'b1;
                if (en && !first_c && (ts_cnt == '1)) ts_wrap <= 1'b1;
            end
        end
    end

    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = mem[rd_ptr][DATA_W-1:0];
    assign rd.rd_ts    = mem[rd_ptr][ENT_W-1:DATA_W];

endmodule

// File: tb/tb_edge_capture_monitor.sv
// Directed bench for edge_capture_monitor (DATA_W=4, TS_W=4, DEPTH=8).
module tb_edge_capture_monitor;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned TS_W   = 4;
    localparam int unsigned DEPTH  = 8;

    logic              sysclk   = 1'b0;
    logic              sysrst_n = 1'b0;
    logic              en       = 1'b0;
    logic              clr      = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic [3:0]        count;
    logic              overflow;
    logic              ts_wrap;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    edge_capture_monitor_if #(.DATA_W(DATA_W), .TS_W(TS_W)) rd_if ();

    edge_capture_monitor #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .sysclk   (sysclk),
        .sysrst_n (sysrst_n),
        .en       (en),
        .clr      (clr),
        .in_data  (in_data),
        .rd       (rd_if),
        .count    (count),
        .overflow (overflow),
        .ts_wrap  (ts_wrap)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input int ts, input int d);
        chk({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
        chk({tag, "_ts"},    32'(rd_if.rd_ts),    32'(ts));
        chk({tag, "_data"},  32'(rd_if.rd_data),  32'(d));
        rd_if.rd_en = 1'b1;
        tick();
        rd_if.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rd_if.rd_en = 1'b0;
        #12;
        chk("rst_count",    32'(count),          32'd0);
        chk("rst_valid",    32'(rd_if.rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow),       32'd0);
        chk("rst_ts_wrap",  32'(ts_wrap),        32'd0);
        sysrst_n = 1'b1;
        tick();

        // Basic pulse: 0 at k=0,1 ; 1 at k=2 ; 0 at k=3,4
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = (k == 2) ? 4'd1 : 4'd0;
            tick();
            if (k == 0) chk("pulse_lat_k0", 32'(count), 32'd0);
        end
        chk("pulse_count", 32'(count), 32'd3);
        en = 1'b0;
        tick();
        pop_chk("pulse_e0", 0, 0);
        pop_chk("pulse_e1", 2, 1);
        pop_chk("pulse_e2", 3, 0);
        chk("pulse_empty", 32'(rd_if.rd_valid), 32'd0);

        // Overflow: toggle every cycle for k=0..11
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_data = 4'(k & 1);
            tick();
        end
        en = 1'b0;
        tick();
        tick();
        chk("ovf_count", 32'(count),    32'd8);
        chk("ovf_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) pop_chk("ovf_entry", i, i & 1);
        chk("ovf_drained", 32'(rd_if.rd_valid), 32'd0);
        chk("ovf_sticky",  32'(overflow),       32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_count",    32'(count),    32'd0);

        // Full push+pop: 8 stored, 9th written on the same edge as a pop
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_data = 4'(k & 1);
            tick();
        end
        chk("full_count_pre", 32'(count), 32'd8);
        en = 1'b0;
        rd_if.rd_en = 1'b1;
        tick();
        rd_if.rd_en = 1'b0;
        chk("full_count_post", 32'(count),    32'd8);
        chk("full_overflow",   32'(overflow), 32'd0);
        for (int i = 1; i < 9; i++) pop_chk("full_entry", i, i & 1);
        chk("full_drained", 32'(rd_if.rd_valid), 32'd0);

        // Timestamp wrap: change 0->5 sampled at k=17 (TS_W=4)
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = (k >= 17) ? 4'd5 : 4'd0;
            tick();
            if (k == 15) chk("wrap_before", 32'(ts_wrap), 32'd0);
            if (k == 16) chk("wrap_set",    32'(ts_wrap), 32'd1);
        end
        pop_chk("wrap_base", 0, 0);
        pop_chk("wrap_entry", 1, 5);
        chk("wrap_drained", 32'(rd_if.rd_valid), 32'd0);
        en = 1'b0;
        tick();
        chk("wrap_sticky", 32'(ts_wrap), 32'd1);
        en = 1'b1;
        tick();
        tick();
        pop_chk("rebase", 0, 5);
        en = 1'b0;
        tick();

        // Reset mid-run with 3 entries stored
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = (k == 3) ? 4'd2 : 4'(k);
            tick();
        end
        chk("mid_count", 32'(count), 32'd3);
        #2;
        sysrst_n = 1'b0;
        #1;
        chk("mid_rst_count",    32'(count),          32'd0);
        chk("mid_rst_valid",    32'(rd_if.rd_valid), 32'd0);
        chk("mid_rst_data",     32'(rd_if.rd_data),  32'd0);
        chk("mid_rst_ts",       32'(rd_if.rd_ts),    32'd0);
        chk("mid_rst_overflow", 32'(overflow),       32'd0);
        chk("mid_rst_ts_wrap",  32'(ts_wrap),        32'd0);
        in_data = 4'hA;
        #1;
        sysrst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_count", 32'(count), 32'd1);
        pop_chk("post_rst", 0, 10);
        en = 1'b0;
        tick();

        // Idle with empty reads
        for (int i = 0; i < 6; i++) begin
            in_data = ~in_data;
            rd_if.rd_en = 1'b1;
            tick();
            chk("idle_count", 32'(count),          32'd0);
            chk("idle_valid", 32'(rd_if.rd_valid), 32'd0);
        end
        rd_if.rd_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/edge_capture_monitor.md
Name: edge_capture_monitor

Overview:
- Observation-side counterpart to the stimulus drivers that feed `main`.
- Samples a DATA_W-bit bus every sysclk and timestamps each value change.
- Stores each {timestamp, value} in a small show-ahead FIFO that a host drains.
- Synthesizable, so it can sit on `main.out` in simulation and on hardware.

Parameters:
- DATA_W, 4: width of the monitored bus.
- TS_W, 12: timestamp counter width.
- DEPTH, 8: number of FIFO entries; must be a power of two and at least 2.

Ports:
- sysclk  in  1  system clock; all logic is on its rising edge.
- sysrst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable (level).
- clr  in  1  synchronous flush of the FIFO, overflow and ts_wrap.
- in_data  in  DATA_W  monitored bus.
- rd_en  in  1  pop the head entry; honoured only when rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  DATA_W  value of the head entry.
- rd_ts  out  TS_W  timestamp of the head entry.
- count  out  $clog2(DEPTH)+1  current number of entries.
- overflow  out  1  sticky: a change was dropped because the FIFO was full.
- ts_wrap  out  1  sticky: the timestamp counter wrapped while in RUN.

Behaviour:
- Reset values: rd_valid=0, rd_data=0, rd_ts=0, count=0, overflow=0, ts_wrap=0; FSM=IDLE; ts_cnt=0; FIFO pointers=0.
- FSM states IDLE and RUN:
  - IDLE->RUN on an edge sampling en=1.
  - RUN->IDLE on an edge sampling en=0.
  - FIFO contents are retained across IDLE.
- Timestamping:
  - Number RUN edges k=0,1,2,...; edge k=0 is the first edge sampling en=1 in IDLE.
  - At edge k: s_val<=in_data, s_ts<=k mod 2^TS_W.
  - ts_cnt restarts at 0 on every IDLE->RUN entry.
- Baseline: the value sampled at k=0 is always pushed, even if it equals the pre-enable value.
- Change detect: for k>=1, push {s_ts, s_val} when the value sampled at k differs from the value sampled at k-1.
- Push latency: a push decided from the edge-k sample is written at edge k+1.
  - count and rd_valid update after edge k+1.
  - If en drops at edge k+1, the pending push from edge k still completes; nothing is sampled at k+1.
- FIFO read:
  - Show-ahead: rd_data/rd_ts reflect the head entry whenever rd_valid=1.
  - rd_en=1 with rd_valid=1 pops at the edge.
  - rd_en with rd_valid=0 is ignored, with no underflow side effects.
- Full:
  - Push with count=DEPTH and no pop: entry dropped, overflow<=1, contents unchanged.
  - Push and pop on the same edge when full: both are accepted and count stays DEPTH.
  - Push and pop on the same edge when empty: the push is accepted, the pop is ignored, count becomes 1.
- ts_wrap: set when ts_cnt goes from 2^TS_W-1 to 0 in RUN. Timestamps simply wrap (modulo arithmetic).
- clr priority: clr=1 overrides push and pop on that edge.
  - Empties the FIFO and clears overflow and ts_wrap.
  - Does not change FSM state or ts_cnt.
  - A push decided at the same edge is discarded.
- Reset mid-operation:
  - Asserting sysrst_n forces all reset values immediately, asynchronously; in-flight pushes are lost.
  - After release, the first capture requires en sampled high, which produces a fresh baseline at k=0.
- Pointer width is $clog2(DEPTH); pointers wrap modulo DEPTH.

Test Plan:
- Basic pulse:
  - Stimulus: in_data=0, en rises before edge 0; in_data=1 sampled at k=2, in_data=0 sampled at k=3; no reads.
  - Required: count=3 after edge 4.
  - Required: pops return (ts=0,0), (ts=2,1), (ts=3,0) in order; rd_valid=0 after the third pop.
- Overflow:
  - Stimulus: DEPTH=8; in_data toggles 0/1 each cycle for k=0..11; no reads.
  - Required: count=8 and overflow=1; the entries hold timestamps 0..7; later changes are dropped.
  - Required: a clr pulse gives count=0 and overflow=0.
- Full push+pop:
  - Stimulus: the FIFO holds 8 entries; rd_en=1 on the same edge a new change is written.
  - Required: count stays 8, the head advances, the new entry is at the tail, overflow=0.
- Timestamp wrap:
  - Stimulus: TS_W=4; en held; in_data changes 0->5 sampled at k=17.
  - Required: the entry is (ts=1,5) and ts_wrap=1.
  - Required: en low then high produces a new baseline with ts=0.
- Reset mid-run:
  - Stimulus: 3 entries stored; sysrst_n pulsed low between edges.
  - Required: all outputs are zero immediately.
  - Required: after release with en=1 and in_data=0xA, the first entry is (ts=0,0xA).
- Idle and empty reads:
  - Stimulus: en=0, in_data toggling, rd_en=1 throughout.
  - Required: count stays 0 and rd_valid stays 0; no state changes.
